ps2_scan_rx: RTL and testbench
==============================

Name: ps2_scan_rx

Overview:
PS/2 device-to-host receiver that sits directly upstream of the keyboard key-decoder. It oversamples the asynchronous ps2_clk/ps2_data lines in the system clock domain and assembles 11-bit frames. Validated scan-code bytes are queued in a small FIFO and presented to the decoder through a ready/rdn pop interface with a sticky overflow flag. The decoder handles E0/F0 prefixes and expects one byte per ready cycle when rdn is tied low.

Parameters:
FIFO_AW, 3, log2 of FIFO depth (depth 8)
TIMEOUT_CYCLES, 20000, idle clk cycles after which a partial frame is abandoned (200 us at 100 MHz)

Ports:
clk  input  1  system clock; all logic on its rising edge
clrn  input  1  synchronous active-low reset
ps2_clk  input  1  raw PS/2 clock line (asynchronous)
ps2_data  input  1  raw PS/2 data line (asynchronous)
rdn  input  1  active-low pop strobe; pops FIFO head when low and ready=1
data  output  8  FIFO head byte; valid only while ready=1
ready  output  1  FIFO non-empty
overflow  output  1  sticky; a completed byte was dropped because the FIFO was full
frame_err  output  1  one-cycle pulse on a discarded malformed frame

Behaviour:
- One clock domain. Reset is synchronous and active-low: clrn sampled low at a clk edge resets everything.
- Reset values: data=8'h00, ready=0, overflow=0, frame_err=0, FIFO pointers=0, bit counter=0, sync registers=3'b111.
- Synchronizer: 3-bit shift registers on ps2_clk and ps2_data. A falling edge is detected when clk_sync[2:1]==2'b10. Data is sampled from data_sync[1] in that same cycle.
- Frame FSM states: IDLE, SHIFT, CHECK.
  - IDLE: on a falling edge with sampled bit 0 (start bit), go to SHIFT with cnt=1. A start bit of 1 is treated as a glitch: stay in IDLE with no error.
  - SHIFT: each falling edge shifts data LSB-first for cnt 1..8, stores parity at cnt 9 and stop at cnt 10, then increments cnt. After cnt 10, go to CHECK.
  - CHECK (one cycle): the frame is good if XOR of the 8 data bits and parity is 1 (odd parity) and stop is 1.
    - Good frame: push the byte.
    - Bad frame: no push; frame_err=1 for this cycle only.
    - Always return to IDLE.
- Latency: a pushed byte makes ready=1 on the clk edge after CHECK, which is 3 clk after the stop-bit falling edge is registered in the synchronizer.
- FIFO behaviour:
  - data is the registered head (mem[rd_ptr]).
  - Pop occurs when ready & ~rdn. Push and pop in the same cycle are both honoured.
  - With rdn tied 0, each byte is visible exactly one cycle with ready=1. Back-to-back bytes give ready high on consecutive cycles with no gap.
  - Full (count==2^FIFO_AW) with push and no pop: the byte is dropped and overflow is set to 1.
  - Full with push and simultaneous pop: the push is accepted, no overflow.
  - Empty with pop: ignored.
  - Pointers wrap modulo depth; count is FIFO_AW+1 bits wide.
- overflow clears on the first successful pop after it was set, or on reset.
- Reset mid-frame: the partial frame is discarded, the FIFO is emptied, and the FSM returns to IDLE. The next falling edge with data 0 starts a fresh frame.

Optional Feature:
Macro PS2_TIMEOUT_EN.
- Defined: an idle counter resets on every ps2_clk falling edge and counts in SHIFT. When it reaches TIMEOUT_CYCLES, the FSM returns to IDLE, the partial frame is dropped, and frame_err pulses once.
- Undefined: no counter. A partial frame waits indefinitely, and the next edges continue that same frame.

Test Plan:
- Frame for 8'h1D (start 0, data bits 1,0,1,1,1,0,0,0, parity 1, stop 1) with rdn=0 -> data=8'h1D with ready=1 for exactly one cycle, frame_err=0.
- Frames E0, F0, 75 sent back-to-back with rdn=0 -> three single-cycle ready pulses carrying 8'hE0, 8'hF0, 8'h75 in that order.
- 8'h72 sent with parity bit 0 (bad), then 8'h72 with parity 1 -> first gives a frame_err pulse and no ready; second gives data=8'h72.
- rdn=1, send 9 frames 01..09 -> after the 9th frame overflow=1, with 8 bytes queued. Then pulse rdn low 8 cycles -> bytes 01..08 in order, overflow=0 after the first pop, ready=0 at the end.
- With PS2_TIMEOUT_EN: send 5 bits, stall 25000 clk, then send a full 8'h29 frame -> one frame_err pulse, then data=8'h29 (no corrupted byte).
- Drop clrn low for 1 cycle after the 6th bit of a frame, then send 8'h43 -> only 8'h43 is received; ready=0 and overflow=0 immediately after reset.

Source files
------------

// File: rtl/ps2_scan_rx.sv
// PS/2 device-to-host receiver: oversampled frame assembly feeding an 8-deep scan-code FIFO.
// Define PS2_TIMEOUT_EN to abandon partial frames after TIMEOUT_CYCLES idle clocks.
module ps2_scan_rx #(
  parameter int FIFO_AW        = 3,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       rdn,
  output logic [7:0] data,
  output logic       ready,
  output logic       overflow,
  output logic       frame_err
);

  localparam int DEPTH = 1 << FIFO_AW;

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

  // Data is only ever sampled from stage 1, so its third stage would be dead logic.
  logic [2:0] clkSync_q;
  logic [1:0] dataSync_q;
  logic       fallEdge;
  logic       sampleBit;

  always_ff @(posedge clk) begin
    if (!clrn) begin
      clkSync_q  <= 3'b111;
      dataSync_q <= 2'b11;
    end else begin
      clkSync_q  <= {clkSync_q[1:0], ps2_clk};
      dataSync_q <= {dataSync_q[0], ps2_data};
    end
  end

  assign fallEdge  = (clkSync_q[2:1] == 2'b10);
  assign sampleBit = dataSync_q[1];

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       parity_q, parity_d;
  logic       stop_q, stop_d;
  logic       push;
  logic       frameErr;
  logic       timeout;

`ifdef PS2_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] idle_q, idle_d;

  assign timeout = (state_q == SHIFT) && (idle_q == TW'(TIMEOUT_CYCLES));

  always_comb begin
    idle_d = '0;
    if (state_q == SHIFT && !fallEdge && !timeout) idle_d = idle_q + TW'(1);
  end

  always_ff @(posedge clk) begin
    if (!clrn) idle_q <= '0;
    else       idle_q <= idle_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!clrn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      stop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      stop_q   <= stop_d;
    end
  end

  // Data bits arrive LSB first, so each new bit enters at the MSB and slides down.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    stop_d   = stop_q;
    push     = 1'b0;
    frameErr = 1'b0;
    case (state_q)
      IDLE: begin
        if (fallEdge && !sampleBit) begin
          state_d = SHIFT;
          cnt_d   = 4'd1;
        end
      end
      SHIFT: begin
        if (timeout) begin
          state_d  = IDLE;
          cnt_d    = '0;
          frameErr = 1'b1;
        end else if (fallEdge) begin
          if (cnt_q <= 4'd8) begin
            shift_d = {sampleBit, shift_q[7:1]};
          end else if (cnt_q == 4'd9) begin
            parity_d = sampleBit;
          end else begin
            stop_d  = sampleBit;
            state_d = CHECK;
          end
          cnt_d = cnt_q + 4'd1;
        end
      end
      CHECK: begin
        push     = (^{shift_q, parity_q}) & stop_q;
        frameErr = ~push;
        state_d  = IDLE;
        cnt_d    = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  logic [7:0]         mem_q [DEPTH];
  logic [FIFO_AW-1:0] wrPtr_q, wrPtr_d;
  logic [FIFO_AW-1:0] rdPtr_q, rdPtr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               overflow_q, overflow_d;
  logic               pop;
  logic               full;
  logic               pushOk;

  assign pop    = ready & ~rdn;
  assign full   = (count_q == (FIFO_AW + 1)'(DEPTH));
  assign pushOk = push & (~full | pop);

  // A pop frees the slot in the same cycle, so a full FIFO can still accept a push.
  always_comb begin
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    overflow_d = overflow_q;
    count_d    = count_q + (FIFO_AW + 1)'(pushOk) - (FIFO_AW + 1)'(pop);
    if (pushOk) wrPtr_d = wrPtr_q + FIFO_AW'(1);
    if (pop)    rdPtr_d = rdPtr_q + FIFO_AW'(1);
    if (push && full && !pop) overflow_d = 1'b1;
    else if (pop)             overflow_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (pushOk) mem_q[wrPtr_q] <= shift_q;
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign data      = mem_q[rdPtr_q];
  assign ready     = (count_q != '0);
  assign overflow  = overflow_q;
  assign frame_err = frameErr;

endmodule

// File: tb/tb_ps2_scan_rx.sv
// Self-checking bench for ps2_scan_rx: directed and random PS/2 frames against a queue-based model.
// Define PS2_TIMEOUT_EN for both files to exercise the partial-frame timeout.
module tb_ps2_scan_rx;

  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       rdn = 1'b1;
  logic [7:0] data;
  logic       ready;
  logic       overflow;
  logic       frame_err;

  int checks = 0;
  int failures = 0;

  byte unsigned rxQ[$];
  byte unsigned expQ[$];
  byte unsigned modelQ[$];
  int  errSeen = 0;
  int  expErr = 0;
  int  readyCycles = 0;
  bit  modelOvf = 0;

  ps2_scan_rx #(.FIFO_AW(3), .TIMEOUT_CYCLES(20000)) dut (
    .clk      (clk),
    .clrn     (clrn),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .rdn      (rdn),
    .data     (data),
    .ready    (ready),
    .overflow (overflow),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Observe popped bytes and error pulses half a cycle away from the active edge.
  always @(negedge clk) begin
    if (clrn) begin
      if (ready) readyCycles++;
      if (ready && !rdn) rxQ.push_back(data);
      if (frame_err) errSeen++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] makeFrame(input logic [7:0] b, input logic badParity, input logic badStop);
    logic p;
    p = ((($countones(b) % 2) == 0) ? 1'b1 : 1'b0) ^ badParity;
    return {~badStop, p, b, 1'b0};
  endfunction

  task automatic sendBits(input logic [10:0] frame, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      ps2_data = frame[i];
      repeat (HALF) @(posedge clk);
      #1 ps2_clk = 1'b0;
      repeat (HALF) @(posedge clk);
      #1 ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  // Model: a frame is good when data plus parity has an odd number of ones and stop is high.
  task automatic modelFrame(input logic [10:0] frame);
    bit good;
    good = (frame[0] == 1'b0) && (($countones(frame[9:1]) % 2) == 1) && frame[10];
    if (!good) expErr++;
    else if (!rdn) expQ.push_back(frame[8:1]);
    else if (modelQ.size() < 8) modelQ.push_back(frame[8:1]);
    else modelOvf = 1;
  endtask

  task automatic applyStimulus(input logic [7:0] b, input logic badParity, input logic badStop);
    logic [10:0] frame;
    frame = makeFrame(b, badParity, badStop);
    sendBits(frame, 0, 10);
    modelFrame(frame);
    repeat (12) @(posedge clk);
    #1;
  endtask

  task automatic checkRx(input string tag);
    int n;
    checkOutput($sformatf("%s_count", tag), rxQ.size(), expQ.size());
    n = (rxQ.size() < expQ.size()) ? rxQ.size() : expQ.size();
    for (int i = 0; i < n; i++) checkOutput($sformatf("%s_byte%0d", tag, i), rxQ[i], expQ[i]);
    checkOutput($sformatf("%s_frameErr", tag), errSeen, expErr);
    rxQ.delete();
    expQ.delete();
    errSeen = 0;
    expErr = 0;
  endtask

  initial begin
    int rc0;
    logic [10:0] fr;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_data", data, 8'h00);
    checkOutput("reset_ready", ready, 1'b0);
    checkOutput("reset_overflow", overflow, 1'b0);
    checkOutput("reset_frameErr", frame_err, 1'b0);
    @(posedge clk);
    #1 clrn = 1'b1;
    rdn = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    rc0 = readyCycles;
    applyStimulus(8'h1D, 1'b0, 1'b0);
    checkRx("single_1D");
    checkOutput("single_readyCycles", readyCycles - rc0, 1);

    rc0 = readyCycles;
    applyStimulus(8'hE0, 1'b0, 1'b0);
    applyStimulus(8'hF0, 1'b0, 1'b0);
    applyStimulus(8'h75, 1'b0, 1'b0);
    checkRx("prefix_seq");
    checkOutput("prefix_readyCycles", readyCycles - rc0, 3);

    applyStimulus(8'h72, 1'b1, 1'b0);
    checkOutput("badParity_noReady", ready, 1'b0);
    applyStimulus(8'h72, 1'b0, 1'b0);
    checkRx("parity_72");

    rdn = 1'b1;
    for (int i = 1; i <= 9; i++) applyStimulus(8'(i), 1'b0, 1'b0);
    checkOutput("fill_overflow", overflow, modelOvf);
    checkOutput("fill_ready", ready, 1'b1);
    checkOutput("fill_head", data, modelQ[0]);
    rdn = 1'b0;
    @(posedge clk);
    #1;
    modelOvf = 0;
    checkOutput("pop1_overflowClear", overflow, modelOvf);
    repeat (7) @(posedge clk);
    #1 rdn = 1'b1;
    while (modelQ.size() > 0) expQ.push_back(modelQ.pop_front());
    checkOutput("drain_ready", ready, 1'b0);
    checkRx("drain");

    applyStimulus(8'h3C, 1'b0, 1'b0);
    checkOutput("preReset_ready", ready, 1'b1);
    sendBits(makeFrame(8'hA5, 1'b0, 1'b0), 0, 5);
    @(posedge clk);
    #1 clrn = 1'b0;
    @(posedge clk);
    #1 clrn = 1'b1;
    modelQ.delete();
    modelOvf = 0;
    checkOutput("midReset_ready", ready, 1'b0);
    checkOutput("midReset_overflow", overflow, 1'b0);
    rdn = 1'b0;
    applyStimulus(8'h43, 1'b0, 1'b0);
    checkRx("afterReset_43");

`ifdef PS2_TIMEOUT_EN
    sendBits(makeFrame(8'h5A, 1'b0, 1'b0), 0, 4);
    repeat (25000) @(posedge clk);
    #1;
    expErr++;
    applyStimulus(8'h29, 1'b0, 1'b0);
    checkRx("timeout_29");
`else
    fr = makeFrame(8'h5A, 1'b0, 1'b0);
    sendBits(fr, 0, 4);
    repeat (300) @(posedge clk);
    #1;
    sendBits(fr, 5, 10);
    modelFrame(fr);
    repeat (12) @(posedge clk);
    #1;
    checkRx("stall_5A");
`endif

    for (int i = 0; i < 20; i++) begin
      applyStimulus(8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0));
    end
    checkRx("random");
    checkOutput("final_overflow", overflow, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
